// File: rtl/forward_scoreboard.sv
// Decode-stage operand forwarding with per-byte merge, a per-register latency
// scoreboard for multi-cycle producers, and a drain FSM for TLB/cache instructions.
module forward_scoreboard #(
    parameter int N_STG  = 4,
    parameter int N_RD   = 2,
    parameter int DATA_W = 32,
    parameter int LAT_W  = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         ds_valid,
    input  logic                         ds_go,
    input  logic [N_RD-1:0]              rd_need,
    input  logic [N_RD*5-1:0]            rd_addr,
    input  logic [N_RD*DATA_W-1:0]       rf_rdata,
    input  logic                         iss_we,
    input  logic [4:0]                   iss_dest,
    input  logic [LAT_W-1:0]             iss_lat,
    input  logic                         iss_serial,
    input  logic [N_STG-1:0]             stg_valid,
    input  logic [N_STG*5-1:0]           stg_dest,
    input  logic [N_STG*(DATA_W/8)-1:0]  stg_be,
    input  logic [N_STG-1:0]             stg_ready,
    input  logic [N_STG*DATA_W-1:0]      stg_result,
    output logic [N_RD*DATA_W-1:0]       rd_value,
    output logic                         ds_stall,
    output logic [31:0]                  sb_busy
);

    localparam int N_BYTE = DATA_W / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LAT_W-1:0] cnt     [32];
    logic [LAT_W-1:0] cnt_nxt [32];

    logic [N_STG-1:0] match [N_RD];
    logic [N_RD-1:0]  live;
    logic [N_RD-1:0]  pend;
    logic [N_RD-1:0]  busy_rd;
    logic             data_haz;
    logic             issue;

    // Issue handshake: decode offers with ds_valid, execute accepts with ds_go,
    // and the instruction moves only when ds_stall is low in that same cycle.
    assign issue = ds_valid & ds_go & ~ds_stall;

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            sb_busy[r] = |cnt[r];
        end
    end

    always_comb begin
        for (int i = 0; i < N_RD; i++) begin
            live[i]    = rd_need[i] & (|rd_addr[i*5 +: 5]);
            busy_rd[i] = |cnt[rd_addr[i*5 +: 5]];
            for (int s = 0; s < N_STG; s++) begin
                match[i][s] = stg_valid[s]
                            & (stg_dest[s*5 +: 5] == rd_addr[i*5 +: 5])
                            & (|stg_dest[s*5 +: 5]);
            end
        end
    end

    // Stages are walked oldest to youngest so the youngest hit is written last.
    always_comb begin
        rd_value = rf_rdata;
        pend     = '0;
        for (int i = 0; i < N_RD; i++) begin
            for (int s = N_STG - 1; s >= 0; s--) begin
                if (match[i][s] && (|stg_be[s*N_BYTE +: N_BYTE])) begin
                    pend[i] = ~stg_ready[s];
                end
                for (int b = 0; b < N_BYTE; b++) begin
                    if (live[i] && match[i][s] && stg_be[s*N_BYTE + b]) begin
                        rd_value[i*DATA_W + b*8 +: 8] = stg_result[s*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
    end

    assign data_haz = |(live & (pend | busy_rd));
    assign ds_stall = ds_valid & (data_haz | (state == DRAIN));

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_nxt[r] = (|cnt[r]) ? (cnt[r] - LAT_W'(1)) : '0;
        end
        if (issue && iss_we && (|iss_dest) && (|iss_lat)) begin
            cnt_nxt[iss_dest] = iss_lat;
        end
        cnt_nxt[0] = '0;
        if (flush) begin
            for (int r = 0; r < 32; r++) begin
                cnt_nxt[r] = '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue && iss_serial) state_nxt = DRAIN;
            DRAIN:   if ((stg_valid == '0) && (sb_busy == '0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard: a table of combinational forwarding
// vectors followed by hand-written multi-cycle scoreboard, drain and reset sequences.
module tb_forward_scoreboard;

    localparam int N_STG  = 4;
    localparam int N_RD   = 2;
    localparam int DATA_W = 32;
    localparam int LAT_W  = 3;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         flush;
    logic                         ds_valid;
    logic                         ds_go;
    logic [N_RD-1:0]              rd_need;
    logic [N_RD*5-1:0]            rd_addr;
    logic [N_RD*DATA_W-1:0]       rf_rdata;
    logic                         iss_we;
    logic [4:0]                   iss_dest;
    logic [LAT_W-1:0]             iss_lat;
    logic                         iss_serial;
    logic [N_STG-1:0]             stg_valid;
    logic [N_STG*5-1:0]           stg_dest;
    logic [N_STG*(DATA_W/8)-1:0]  stg_be;
    logic [N_STG-1:0]             stg_ready;
    logic [N_STG*DATA_W-1:0]      stg_result;
    logic [N_RD*DATA_W-1:0]       rd_value;
    logic                         ds_stall;
    logic [31:0]                  sb_busy;

    int n_total = 0;
    int n_pass  = 0;

    forward_scoreboard #(
        .N_STG(N_STG), .N_RD(N_RD), .DATA_W(DATA_W), .LAT_W(LAT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .ds_valid(ds_valid), .ds_go(ds_go),
        .rd_need(rd_need), .rd_addr(rd_addr), .rf_rdata(rf_rdata),
        .iss_we(iss_we), .iss_dest(iss_dest), .iss_lat(iss_lat), .iss_serial(iss_serial),
        .stg_valid(stg_valid), .stg_dest(stg_dest), .stg_be(stg_be),
        .stg_ready(stg_ready), .stg_result(stg_result),
        .rd_value(rd_value), .ds_stall(ds_stall), .sb_busy(sb_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   need;
        logic [9:0]   addr;
        logic [63:0]  rf;
        logic [3:0]   valid;
        logic [19:0]  dest;
        logic [15:0]  be;
        logic [3:0]   ready;
        logic [127:0] result;
        logic [31:0]  exp0;
        logic [31:0]  exp1;
        logic         exp_stall;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush      = 1'b0;
        ds_go      = 1'b0;
        rd_need    = '0;
        rd_addr    = '0;
        rf_rdata   = '0;
        iss_we     = 1'b0;
        iss_dest   = '0;
        iss_lat    = '0;
        iss_serial = 1'b0;
        stg_valid  = '0;
        stg_dest   = '0;
        stg_be     = '0;
        stg_ready  = '0;
        stg_result = '0;
    endtask

    initial begin
        vecs[0]  = '{2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, 4'b0001,
                     {5'd0, 5'd0, 5'd0, 5'd5}, 16'h000F, 4'b0001,
                     {96'h0, 32'h11223344}, 32'h11223344, 32'h0, 1'b0};
        vecs[1]  = '{2'b11, {5'd3, 5'd3}, {32'h55555555, 32'h12345678}, 4'b0101,
                     {5'd0, 5'd3, 5'd0, 5'd3}, 16'h0C03, 4'b1111,
                     {32'h0, 32'hCCCC0000, 32'h0, 32'hAAAABBBB}, 32'hCCCCBBBB, 32'hCCCCBBBB, 1'b0};
        vecs[2]  = '{2'b00, {5'd3, 5'd3}, {32'h55555555, 32'h12345678}, 4'b0101,
                     {5'd0, 5'd3, 5'd0, 5'd3}, 16'h0C03, 4'b1111,
                     {32'h0, 32'hCCCC0000, 32'h0, 32'hAAAABBBB}, 32'h12345678, 32'h55555555, 1'b0};
        vecs[3]  = '{2'b01, {5'd0, 5'd9}, {32'h0, 32'hFFFFFFFF}, 4'b0011,
                     {5'd0, 5'd0, 5'd9, 5'd9}, 16'h00FF, 4'b0011,
                     {64'h0, 32'h02020202, 32'h01010101}, 32'h01010101, 32'h0, 1'b0};
        vecs[4]  = '{2'b01, {5'd0, 5'd6}, {32'h0, 32'h0}, 4'b0010,
                     {5'd0, 5'd0, 5'd6, 5'd0}, 16'h00F0, 4'b0000,
                     {64'h0, 32'h77777777, 32'h0}, 32'h77777777, 32'h0, 1'b1};
        vecs[5]  = '{2'b00, {5'd0, 5'd6}, {32'h0, 32'h0}, 4'b0010,
                     {5'd0, 5'd0, 5'd6, 5'd0}, 16'h00F0, 4'b0000,
                     {64'h0, 32'h77777777, 32'h0}, 32'h0, 32'h0, 1'b0};
        vecs[6]  = '{2'b01, {5'd0, 5'd0}, {32'h0, 32'h12121212}, 4'b0001,
                     {5'd0, 5'd0, 5'd0, 5'd0}, 16'h000F, 4'b0000,
                     {96'h0, 32'h99999999}, 32'h12121212, 32'h0, 1'b0};
        vecs[7]  = '{2'b01, {5'd0, 5'd4}, {32'h0, 32'h44444444}, 4'b0000,
                     {5'd0, 5'd0, 5'd0, 5'd4}, 16'h000F, 4'b0000,
                     {96'h0, 32'h99999999}, 32'h44444444, 32'h0, 1'b0};
        vecs[8]  = '{2'b01, {5'd0, 5'd8}, {32'h0, 32'h0}, 4'b1001,
                     {5'd8, 5'd0, 5'd0, 5'd8}, 16'hF00F, 4'b0001,
                     {32'h33333333, 64'h0, 32'h88888888}, 32'h88888888, 32'h0, 1'b0};
        vecs[9]  = '{2'b01, {5'd0, 5'd8}, {32'h0, 32'h0}, 4'b0011,
                     {5'd0, 5'd0, 5'd8, 5'd8}, 16'h00F0, 4'b0010,
                     {64'h0, 32'h0BADF00D, 32'hFFFFFFFF}, 32'h0BADF00D, 32'h0, 1'b0};
        vecs[10] = '{2'b10, {5'd2, 5'd0}, {32'h00112233, 32'hABCDEF01}, 4'b0010,
                     {5'd0, 5'd0, 5'd2, 5'd0}, 16'h0080, 4'b0010,
                     {64'h0, 32'hAB000000, 32'h0}, 32'hABCDEF01, 32'hAB112233, 1'b0};
        vecs[11] = '{2'b10, {5'd6, 5'd6}, {32'h00000001, 32'h00000002}, 4'b0010,
                     {5'd0, 5'd0, 5'd6, 5'd0}, 16'h00F0, 4'b0000,
                     {64'h0, 32'h77777777, 32'h0}, 32'h00000002, 32'h77777777, 1'b1};

        // Clock/reset
        clear_inputs();
        ds_valid = 1'b1;
        reset    = 1'b1;
        #12;
        reset = 1'b0;
        tick();
        check("reset_busy", sb_busy, 32'h0);
        check("reset_stall", {31'h0, ds_stall}, 32'h0);

        // Combinational forwarding table
        for (int k = 0; k < 12; k++) begin
            rd_need    = vecs[k].need;
            rd_addr    = vecs[k].addr;
            rf_rdata   = vecs[k].rf;
            stg_valid  = vecs[k].valid;
            stg_dest   = vecs[k].dest;
            stg_be     = vecs[k].be;
            stg_ready  = vecs[k].ready;
            stg_result = vecs[k].result;
            #1;
            check($sformatf("vec%0d_value0", k), rd_value[31:0], vecs[k].exp0);
            check($sformatf("vec%0d_value1", k), rd_value[63:32], vecs[k].exp1);
            check($sformatf("vec%0d_stall", k), {31'h0, ds_stall}, {31'h0, vecs[k].exp_stall});
        end
        clear_inputs();
        tick();

        // Scoreboard latency: r7 lat=3 stalls a reader for three cycles
        ds_go = 1'b1; iss_we = 1'b1; iss_dest = 5'd7; iss_lat = 3'd3;
        #1;
        check("lat_issue_stall", {31'h0, ds_stall}, 32'h0);
        tick();
        iss_we = 1'b0; iss_dest = '0; iss_lat = '0; ds_go = 1'b0;
        rd_need = 2'b01; rd_addr = {5'd0, 5'd7};
        #1;
        check("lat_busy", sb_busy, 32'h00000080);
        check("lat_c1", {31'h0, ds_stall}, 32'h1);
        tick();
        check("lat_c2", {31'h0, ds_stall}, 32'h1);
        tick();
        check("lat_c3", {31'h0, ds_stall}, 32'h1);
        tick();
        check("lat_c4", {31'h0, ds_stall}, 32'h0);
        check("lat_c4_busy", sb_busy, 32'h0);

        // Reload r7 with lat=2 while its counter is at 1
        rd_need = 2'b00;
        ds_go = 1'b1; iss_we = 1'b1; iss_dest = 5'd7; iss_lat = 3'd3;
        tick();
        iss_we = 1'b0;
        tick();
        tick();
        iss_we = 1'b1; iss_dest = 5'd7; iss_lat = 3'd2;
        tick();
        iss_we = 1'b0; iss_dest = '0; iss_lat = '0; ds_go = 1'b0;
        rd_need = 2'b01; rd_addr = {5'd0, 5'd7};
        #1;
        check("reload_busy", sb_busy, 32'h00000080);
        check("reload_c1", {31'h0, ds_stall}, 32'h1);
        tick();
        check("reload_c2", {31'h0, ds_stall}, 32'h1);
        tick();
        check("reload_c3", {31'h0, ds_stall}, 32'h0);

        // Register zero, lat=0, and no issue without ds_go
        rd_need = 2'b00;
        ds_go = 1'b1; iss_we = 1'b1; iss_dest = 5'd0; iss_lat = 3'd3;
        tick();
        check("r0_busy", sb_busy, 32'h0);
        iss_dest = 5'd10; iss_lat = 3'd0;
        tick();
        check("lat0_busy", sb_busy, 32'h0);
        ds_go = 1'b0; iss_dest = 5'd11; iss_lat = 3'd3;
        tick();
        check("nogo_busy", sb_busy, 32'h0);
        iss_we = 1'b0; iss_dest = '0; iss_lat = '0;

        // Not-ready producer holds decode until its result is final
        stg_valid = 4'b0010; stg_dest = {5'd0, 5'd0, 5'd6, 5'd0}; stg_be = 16'h00F0;
        stg_ready = 4'b0000; rd_need = 2'b01; rd_addr = {5'd0, 5'd6};
        #1;
        check("nrdy_c1", {31'h0, ds_stall}, 32'h1);
        tick();
        check("nrdy_c2", {31'h0, ds_stall}, 32'h1);
        stg_ready = 4'b0010;
        #1;
        check("nrdy_done", {31'h0, ds_stall}, 32'h0);
        clear_inputs();
        tick();

        // Serial drain waiting on occupied stages
        ds_go = 1'b1; iss_serial = 1'b1; stg_valid = 4'b0110;
        #1;
        check("drain_issue", {31'h0, ds_stall}, 32'h0);
        tick();
        iss_serial = 1'b0; ds_go = 1'b0;
        check("drain_c1", {31'h0, ds_stall}, 32'h1);
        ds_valid = 1'b0;
        #1;
        check("drain_nvalid", {31'h0, ds_stall}, 32'h0);
        ds_valid = 1'b1;
        tick();
        check("drain_c2", {31'h0, ds_stall}, 32'h1);
        stg_valid = 4'b0000;
        #1;
        check("drain_empty", {31'h0, ds_stall}, 32'h1);
        tick();
        check("drain_done", {31'h0, ds_stall}, 32'h0);

        // Serial drain waiting on the scoreboard
        ds_go = 1'b1; iss_serial = 1'b1; iss_we = 1'b1; iss_dest = 5'd12; iss_lat = 3'd2;
        tick();
        iss_serial = 1'b0; iss_we = 1'b0; iss_dest = '0; iss_lat = '0; ds_go = 1'b0;
        check("drain_sb_c1", {31'h0, ds_stall}, 32'h1);
        tick();
        check("drain_sb_c2", {31'h0, ds_stall}, 32'h1);
        tick();
        check("drain_sb_c3", {31'h0, ds_stall}, 32'h1);
        tick();
        check("drain_sb_done", {31'h0, ds_stall}, 32'h0);

        // Flush mid-drain, flush against issue
        ds_go = 1'b1; iss_serial = 1'b1; stg_valid = 4'b0110;
        tick();
        iss_serial = 1'b0; ds_go = 1'b0;
        check("flush_pre", {31'h0, ds_stall}, 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_drain", {31'h0, ds_stall}, 32'h0);
        stg_valid = 4'b0000;
        ds_go = 1'b1; iss_we = 1'b1; iss_dest = 5'd13; iss_lat = 3'd3; iss_serial = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0; iss_serial = 1'b0; iss_dest = 5'd14; iss_lat = 3'd4;
        check("flush_issue_busy", sb_busy, 32'h0);
        check("flush_issue_stall", {31'h0, ds_stall}, 32'h0);
        tick();
        iss_we = 1'b0; iss_dest = '0; iss_lat = '0; ds_go = 1'b0;
        check("flush_cnt_pre", sb_busy, 32'h00004000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_cnt", sb_busy, 32'h0);

        // Asynchronous reset during drain with r4 busy
        stg_valid = 4'b0110;
        ds_go = 1'b1; iss_serial = 1'b1; iss_we = 1'b1; iss_dest = 5'd4; iss_lat = 3'd5;
        tick();
        iss_serial = 1'b0; iss_we = 1'b0; iss_dest = '0; iss_lat = '0; ds_go = 1'b0;
        check("rst_pre_busy", sb_busy, 32'h00000010);
        check("rst_pre_stall", {31'h0, ds_stall}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_busy", sb_busy, 32'h0);
        check("rst_async_stall", {31'h0, ds_stall}, 32'h0);
        #2;
        reset = 1'b0;
        stg_valid = 4'b0000;
        tick();
        check("rst_after", {31'h0, ds_stall}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
